// File: rtl/predecode_queue_if.sv
// rtl/predecode_queue_if.sv - fetch/rename handshake bundle for predecode_queue
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef ALU_TYPE_INT
`define ALU_TYPE_INT 2'd0
`endif
`ifndef ALU_TYPE_MUL
`define ALU_TYPE_MUL 2'd1
`endif
`ifndef ALU_TYPE_MEM
`define ALU_TYPE_MEM 2'd2
`endif
`ifndef ALU_TYPE_FO
`define ALU_TYPE_FO 2'd3
`endif

interface predecode_queue_if #(
    parameter int LANES    = 2,
    parameter int DEPTH    = 4,
    parameter int GHR_BITS = `BP_GHR_BITS
);
    localparam int AW = `INST_ADDR_WIDTH;
    localparam int RW = `REG_ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*32-1:0]      in_inst;
    logic [LANES-1:0]         in_lane_valid;
    logic [LANES-1:0]         in_pred_taken;
    logic [LANES*AW-1:0]      in_pred_target;
    logic [LANES*GHR_BITS-1:0] in_pred_hist;

    logic                     out_valid;
    logic                     out_ready;
    logic [LANES-1:0]         out_lane_valid;
    logic [LANES*2-1:0]       out_fu_type;
    logic [LANES*RW-1:0]      out_rs1;
    logic [LANES*RW-1:0]      out_rs2;
    logic [LANES*RW-1:0]      out_rd;
    logic [LANES*DW-1:0]      out_imm;
    logic [LANES-1:0]         out_use_imm;
    logic [LANES-1:0]         out_rs1_is_fp;
    logic [LANES-1:0]         out_rs2_is_fp;
    logic [LANES-1:0]         out_rd_is_fp;
    logic [LANES-1:0]         out_illegal;
    logic [LANES-1:0]         out_pred_taken;
    logic [LANES*AW-1:0]      out_pred_target;
    logic [LANES*GHR_BITS-1:0] out_pred_hist;
    logic [CW-1:0]            out_count;

    modport master (
        output in_valid, in_inst, in_lane_valid, in_pred_taken, in_pred_target, in_pred_hist,
        input  in_ready,
        input  out_valid, out_lane_valid, out_fu_type, out_rs1, out_rs2, out_rd, out_imm,
               out_use_imm, out_rs1_is_fp, out_rs2_is_fp, out_rd_is_fp, out_illegal,
               out_pred_taken, out_pred_target, out_pred_hist, out_count,
        output out_ready
    );

    modport slave (
        input  in_valid, in_inst, in_lane_valid, in_pred_taken, in_pred_target, in_pred_hist,
        output in_ready,
        output out_valid, out_lane_valid, out_fu_type, out_rs1, out_rs2, out_rd, out_imm,
               out_use_imm, out_rs1_is_fp, out_rs2_is_fp, out_rd_is_fp, out_illegal,
               out_pred_taken, out_pred_target, out_pred_hist, out_count,
        input  out_ready
    );
endinterface

// File: rtl/predecode_queue.sv
// rtl/predecode_queue.sv - multi-lane RISC-V pre-decoder feeding a batch FIFO (PREDECODE_FP_EN enables FP opcode decode)
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef ALU_TYPE_INT
`define ALU_TYPE_INT 2'd0
`endif
`ifndef ALU_TYPE_MUL
`define ALU_TYPE_MUL 2'd1
`endif
`ifndef ALU_TYPE_MEM
`define ALU_TYPE_MEM 2'd2
`endif
`ifndef ALU_TYPE_FO
`define ALU_TYPE_FO 2'd3
`endif

module predecode_queue #(
    parameter int LANES    = 2,
    parameter int DEPTH    = 4,
    parameter int GHR_BITS = `BP_GHR_BITS
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    predecode_queue_if.slave bus
);
    localparam int AW = `INST_ADDR_WIDTH;
    localparam int RW = `REG_ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Major opcodes, inst[6:2]
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_LOAD_FP  = 5'b00001;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_STORE_FP = 5'b01001;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_MADD     = 5'b10000;
    localparam logic [4:0] OPC_MSUB     = 5'b10001;
    localparam logic [4:0] OPC_NMSUB    = 5'b10010;
    localparam logic [4:0] OPC_NMADD    = 5'b10011;
    localparam logic [4:0] OPC_OP_FP    = 5'b10100;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

    typedef struct packed {
        logic [1:0]    fu_type;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic [DW-1:0] imm;
        logic          use_imm;
        logic          rs1_is_fp;
        logic          rs2_is_fp;
        logic          rd_is_fp;
        logic          illegal;
    } dec_t;

    localparam dec_t DEC_RESET = '{fu_type: `ALU_TYPE_INT, default: '0};

    // Single-instruction decode; unknown or compressed encodings collapse to an illegal INT slot.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t     d;
        logic     known;
        logic     no_rs1;
        logic     has_rs2;
        logic     no_rd;
        imm_fmt_e fmt;
        d       = DEC_RESET;
        known   = 1'b0;
        no_rs1  = 1'b0;
        has_rs2 = 1'b0;
        no_rd   = 1'b0;
        fmt     = FMT_NONE;
        case (inst[6:2])
            OPC_LOAD: begin
                known = 1'b1; d.fu_type = `ALU_TYPE_MEM; fmt = FMT_I; d.use_imm = 1'b1;
            end
            OPC_MISC_MEM: begin
                known = 1'b1; d.fu_type = `ALU_TYPE_MEM; fmt = FMT_I; d.use_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                known = 1'b1; fmt = FMT_I; d.use_imm = 1'b1;
            end
            OPC_AUIPC: begin
                known = 1'b1; fmt = FMT_U; d.use_imm = 1'b1; no_rs1 = 1'b1;
            end
            OPC_STORE: begin
                known = 1'b1; d.fu_type = `ALU_TYPE_MEM; fmt = FMT_S; d.use_imm = 1'b1;
                has_rs2 = 1'b1; no_rd = 1'b1;
            end
            OPC_OP: begin
                known = 1'b1; has_rs2 = 1'b1;
                if (inst[31:25] == 7'b0000001) d.fu_type = `ALU_TYPE_MUL;
            end
            OPC_LUI: begin
                known = 1'b1; fmt = FMT_U; d.use_imm = 1'b1; no_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                known = 1'b1; fmt = FMT_B; d.use_imm = 1'b1; has_rs2 = 1'b1; no_rd = 1'b1;
            end
            OPC_JALR: begin
                known = 1'b1; fmt = FMT_I; d.use_imm = 1'b1;
            end
            OPC_JAL: begin
                known = 1'b1; fmt = FMT_J; d.use_imm = 1'b1; no_rs1 = 1'b1;
            end
            OPC_SYSTEM: begin
                known = 1'b1; fmt = FMT_I; d.use_imm = 1'b1;
            end
`ifdef PREDECODE_FP_EN
            OPC_LOAD_FP: begin
                known = 1'b1; d.fu_type = `ALU_TYPE_FO; fmt = FMT_I; d.rd_is_fp = 1'b1;
            end
            OPC_STORE_FP: begin
                known = 1'b1; d.fu_type = `ALU_TYPE_FO; fmt = FMT_S; has_rs2 = 1'b1;
                no_rd = 1'b1; d.rs2_is_fp = 1'b1;
            end
            OPC_OP_FP, OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD: begin
                known = 1'b1; d.fu_type = `ALU_TYPE_FO; has_rs2 = 1'b1;
                d.rs1_is_fp = 1'b1; d.rs2_is_fp = 1'b1; d.rd_is_fp = 1'b1;
            end
`endif
            default: known = 1'b0;
        endcase

        d.rs1 = no_rs1  ? '0 : inst[19:15];
        d.rs2 = has_rs2 ? inst[24:20] : '0;
        d.rd  = no_rd   ? '0 : inst[11:7];

        case (fmt)
            FMT_I:   d.imm = {{(DW-12){inst[31]}}, inst[31:20]};
            FMT_S:   d.imm = {{(DW-12){inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   d.imm = {{(DW-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   d.imm = DW'({inst[31:12], 12'b0});
            FMT_J:   d.imm = {{(DW-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: d.imm = '0;
        endcase

        if (!known || (inst[1:0] != 2'b11)) begin
            d         = DEC_RESET;
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    dec_t [LANES-1:0]               in_dec;
    logic [LANES-1:0]               in_taken;
    logic [LANES-1:0][AW-1:0]       in_target;
    logic [LANES-1:0][GHR_BITS-1:0] in_hist;

    logic [LANES-1:0]               mem_lane_valid [DEPTH];
    dec_t [LANES-1:0]               mem_dec        [DEPTH];
    logic [LANES-1:0]               mem_taken      [DEPTH];
    logic [LANES-1:0][AW-1:0]       mem_target     [DEPTH];
    logic [LANES-1:0][GHR_BITS-1:0] mem_hist       [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          in_ready;
    logic          out_valid;
    logic          push;
    logic          pop;

    // Ready/valid come only from occupancy so rename stalls never reach the decode path.
    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = bus.in_valid & in_ready & (|bus.in_lane_valid) & ~flush;
    assign pop       = out_valid & bus.out_ready & ~flush;

    // Decode every lane; invalid lanes are zeroed, prediction metadata included.
    always_comb begin
        in_dec    = '0;
        in_taken  = '0;
        in_target = '0;
        in_hist   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.in_lane_valid[i]) begin
                in_dec[i]    = decode(bus.in_inst[i*32 +: 32]);
                in_taken[i]  = bus.in_pred_taken[i];
                in_target[i] = bus.in_pred_target[i*AW +: AW];
                in_hist[i]   = bus.in_pred_hist[i*GHR_BITS +: GHR_BITS];
            end
        end
    end

    // Batch FIFO: reset clears everything, flush only rewinds pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_lane_valid[e] <= '0;
                mem_taken[e]      <= '0;
                mem_target[e]     <= '0;
                mem_hist[e]       <= '0;
                for (int l = 0; l < LANES; l++) begin
                    mem_dec[e][l] <= DEC_RESET;
                end
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_lane_valid[wr_ptr] <= bus.in_lane_valid;
                mem_dec[wr_ptr]        <= in_dec;
                mem_taken[wr_ptr]      <= in_taken;
                mem_target[wr_ptr]     <= in_target;
                mem_hist[wr_ptr]       <= in_hist;
                wr_ptr                 <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    dec_t [LANES-1:0]    head_dec;
    logic [LANES*2-1:0]  head_fu;
    logic [LANES*RW-1:0] head_rs1;
    logic [LANES*RW-1:0] head_rs2;
    logic [LANES*RW-1:0] head_rd;
    logic [LANES*DW-1:0] head_imm;
    logic [LANES-1:0]    head_use_imm;
    logic [LANES-1:0]    head_rs1_fp;
    logic [LANES-1:0]    head_rs2_fp;
    logic [LANES-1:0]    head_rd_fp;
    logic [LANES-1:0]    head_illegal;

    assign head_dec = mem_dec[rd_ptr];

    // Flatten the head entry's decoded lanes onto the output buses.
    always_comb begin
        head_fu      = '0;
        head_rs1     = '0;
        head_rs2     = '0;
        head_rd      = '0;
        head_imm     = '0;
        head_use_imm = '0;
        head_rs1_fp  = '0;
        head_rs2_fp  = '0;
        head_rd_fp   = '0;
        head_illegal = '0;
        for (int i = 0; i < LANES; i++) begin
            head_fu[i*2 +: 2]   = head_dec[i].fu_type;
            head_rs1[i*RW +: RW] = head_dec[i].rs1;
            head_rs2[i*RW +: RW] = head_dec[i].rs2;
            head_rd[i*RW +: RW]  = head_dec[i].rd;
            head_imm[i*DW +: DW] = head_dec[i].imm;
            head_use_imm[i]      = head_dec[i].use_imm;
            head_rs1_fp[i]       = head_dec[i].rs1_is_fp;
            head_rs2_fp[i]       = head_dec[i].rs2_is_fp;
            head_rd_fp[i]        = head_dec[i].rd_is_fp;
            head_illegal[i]      = head_dec[i].illegal;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = out_valid;
    assign bus.out_count       = count;
    assign bus.out_lane_valid  = mem_lane_valid[rd_ptr];
    assign bus.out_fu_type     = head_fu;
    assign bus.out_rs1         = head_rs1;
    assign bus.out_rs2         = head_rs2;
    assign bus.out_rd          = head_rd;
    assign bus.out_imm         = head_imm;
    assign bus.out_use_imm     = head_use_imm;
    assign bus.out_rs1_is_fp   = head_rs1_fp;
    assign bus.out_rs2_is_fp   = head_rs2_fp;
    assign bus.out_rd_is_fp    = head_rd_fp;
    assign bus.out_illegal     = head_illegal;
    assign bus.out_pred_taken  = mem_taken[rd_ptr];
    assign bus.out_pred_target = mem_target[rd_ptr];
    assign bus.out_pred_hist   = mem_hist[rd_ptr];
endmodule

// File: tb/tb_predecode_queue.sv
// tb/tb_predecode_queue.sv - scoreboard bench for predecode_queue (honours PREDECODE_FP_EN)
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_TYPE_INT
`define ALU_TYPE_INT 2'd0
`endif
`ifndef ALU_TYPE_MUL
`define ALU_TYPE_MUL 2'd1
`endif
`ifndef ALU_TYPE_MEM
`define ALU_TYPE_MEM 2'd2
`endif
`ifndef ALU_TYPE_FO
`define ALU_TYPE_FO 2'd3
`endif

module tb_predecode_queue;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int GHR   = 8;
    localparam int AW    = `INST_ADDR_WIDTH;
    localparam int RW    = `REG_ADDR_WIDTH;
    localparam int DW    = `DATA_WIDTH;
    localparam int TW    = LANES * AW;
    localparam int HW    = LANES * GHR;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    predecode_queue_if #(.LANES(LANES), .DEPTH(DEPTH), .GHR_BITS(GHR)) bus ();

    predecode_queue #(.LANES(LANES), .DEPTH(DEPTH), .GHR_BITS(GHR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    fu;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic [DW-1:0] imm;
        logic          use_imm;
        logic          rs1_fp;
        logic          rs2_fp;
        logic          rd_fp;
        logic          illegal;
        logic          taken;
        logic [AW-1:0] target;
        logic [GHR-1:0] hist;
    } lane_t;

    typedef struct packed {
        logic [LANES-1:0]  lv;
        lane_t [LANES-1:0] ln;
    } entry_t;

    entry_t model_q[$];
    int     model_count = 0;
    int     errors = 0;
    int     checks = 0;
    bit     mon_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the ISA opcode table.
    function automatic lane_t ref_lane(input logic [31:0] inst, input logic v, input logic tk,
                                       input logic [AW-1:0] tg, input logic [GHR-1:0] hs);
        lane_t r;
        logic [DW-1:0] ii, si, bi, ui, ji;
        bit ok, u1, u2, ud;
        r = '0;
        if (!v) return r;
        r.taken = tk; r.target = tg; r.hist = hs;
        ii = DW'($signed(inst[31:20]));
        si = DW'($signed({inst[31:25], inst[11:7]}));
        bi = DW'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        ui = DW'({inst[31:12], 12'h000});
        ji = DW'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        ok = 1; u1 = 0; u2 = 0; ud = 0;
        case (inst[6:0])
            7'h03: begin r.fu = `ALU_TYPE_MEM; u1 = 1; ud = 1; r.imm = ii; r.use_imm = 1; end
            7'h0F: begin r.fu = `ALU_TYPE_MEM; u1 = 1; ud = 1; r.imm = ii; r.use_imm = 1; end
            7'h13: begin r.fu = `ALU_TYPE_INT; u1 = 1; ud = 1; r.imm = ii; r.use_imm = 1; end
            7'h17: begin r.fu = `ALU_TYPE_INT; ud = 1; r.imm = ui; r.use_imm = 1; end
            7'h23: begin r.fu = `ALU_TYPE_MEM; u1 = 1; u2 = 1; r.imm = si; r.use_imm = 1; end
            7'h33: begin
                r.fu = (inst[31:25] == 7'h01) ? `ALU_TYPE_MUL : `ALU_TYPE_INT;
                u1 = 1; u2 = 1; ud = 1;
            end
            7'h37: begin r.fu = `ALU_TYPE_INT; ud = 1; r.imm = ui; r.use_imm = 1; end
            7'h63: begin r.fu = `ALU_TYPE_INT; u1 = 1; u2 = 1; r.imm = bi; r.use_imm = 1; end
            7'h67: begin r.fu = `ALU_TYPE_INT; u1 = 1; ud = 1; r.imm = ii; r.use_imm = 1; end
            7'h6F: begin r.fu = `ALU_TYPE_INT; ud = 1; r.imm = ji; r.use_imm = 1; end
            7'h73: begin r.fu = `ALU_TYPE_INT; u1 = 1; ud = 1; r.imm = ii; r.use_imm = 1; end
`ifdef PREDECODE_FP_EN
            7'h07: begin r.fu = `ALU_TYPE_FO; u1 = 1; ud = 1; r.imm = ii; r.rd_fp = 1; end
            7'h27: begin r.fu = `ALU_TYPE_FO; u1 = 1; u2 = 1; r.imm = si; r.rs2_fp = 1; end
            7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: begin
                r.fu = `ALU_TYPE_FO; u1 = 1; u2 = 1; ud = 1;
                r.rs1_fp = 1; r.rs2_fp = 1; r.rd_fp = 1;
            end
`endif
            default: ok = 0;
        endcase
        if (u1) r.rs1 = inst[19:15];
        if (u2) r.rs2 = inst[24:20];
        if (ud) r.rd  = inst[11:7];
        if (!ok) begin
            r = '0;
            r.fu = `ALU_TYPE_INT; r.illegal = 1;
            r.taken = tk; r.target = tg; r.hist = hs;
        end
        return r;
    endfunction

    function automatic entry_t ref_entry();
        entry_t e;
        e.lv = bus.in_lane_valid;
        for (int l = 0; l < LANES; l++)
            e.ln[l] = ref_lane(bus.in_inst[l*32 +: 32], bus.in_lane_valid[l], bus.in_pred_taken[l],
                               bus.in_pred_target[l*AW +: AW], bus.in_pred_hist[l*GHR +: GHR]);
        return e;
    endfunction

    function automatic entry_t dut_entry();
        entry_t e;
        e.lv = bus.out_lane_valid;
        for (int l = 0; l < LANES; l++) begin
            e.ln[l].fu      = bus.out_fu_type[l*2 +: 2];
            e.ln[l].rs1     = bus.out_rs1[l*RW +: RW];
            e.ln[l].rs2     = bus.out_rs2[l*RW +: RW];
            e.ln[l].rd      = bus.out_rd[l*RW +: RW];
            e.ln[l].imm     = bus.out_imm[l*DW +: DW];
            e.ln[l].use_imm = bus.out_use_imm[l];
            e.ln[l].rs1_fp  = bus.out_rs1_is_fp[l];
            e.ln[l].rs2_fp  = bus.out_rs2_is_fp[l];
            e.ln[l].rd_fp   = bus.out_rd_is_fp[l];
            e.ln[l].illegal = bus.out_illegal[l];
            e.ln[l].taken   = bus.out_pred_taken[l];
            e.ln[l].target  = bus.out_pred_target[l*AW +: AW];
            e.ln[l].hist    = bus.out_pred_hist[l*GHR +: GHR];
        end
        return e;
    endfunction

    wire model_push = bus.in_valid && (model_count < DEPTH) && (bus.in_lane_valid != '0);

    // Reference occupancy model: accepted batches enter the expected queue at the clock edge.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            model_q.delete();
            model_count <= 0;
        end else begin
            if (model_push) model_q.push_back(ref_entry());
            model_count <= model_count + (model_push ? 1 : 0)
                           - ((model_count != 0 && bus.out_ready) ? 1 : 0);
        end
    end

    // Monitor: flow-control checks each cycle; head compared while presented, popped on consume.
    always @(negedge clk) begin
        entry_t exp_e;
        if (mon_en) begin
            chk("out_count", bus.out_count, model_count);
            chk("in_ready", bus.in_ready, model_count < DEPTH);
            chk("out_valid", bus.out_valid, model_count != 0);
            if (bus.out_valid && model_q.size() != 0) begin
                if (bus.out_ready && !flush && rst_n) exp_e = model_q.pop_front();
                else exp_e = model_q[0];
                chk("head", dut_entry(), exp_e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [LANES-1:0] m, input logic [31:0] i0,
                         input logic [31:0] i1);
        bus.in_valid       = v;
        bus.in_lane_valid  = m;
        bus.in_inst        = {i1, i0};
        bus.in_pred_taken  = LANES'($urandom());
        bus.in_pred_target = TW'({$urandom(), $urandom()});
        bus.in_pred_hist   = HW'($urandom());
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [19] = '{7'h03, 7'h07, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33, 7'h37,
                                  7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B};
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 7) == 0) return r;
        r[6:0] = ops[$urandom_range(0, 18)];
        if (r[6:0] == 7'h33 && $urandom_range(0, 1) == 1) r[31:25] = 7'h01;
        return r;
    endfunction

    initial begin
        bus.out_ready = 1'b0;
        drive(1'b0, '0, 32'h0, 32'h0);
        @(posedge clk);
        mon_en = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_count", bus.out_count, 0);
        chk("rst_fu", bus.out_fu_type, {`ALU_TYPE_INT, `ALU_TYPE_INT});
        chk("rst_imm", bus.out_imm, 0);
        chk("rst_target", bus.out_pred_target, 0);
        chk("rst_lane_valid", bus.out_lane_valid, 0);
        cyc();
        rst_n = 1'b1;

        // addi / add pair
        drive(1'b1, 2'b11, 32'h00500093, 32'h002081B3);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_rd0", bus.out_rd[0 +: RW], 1);
        chk("t1_rs1_0", bus.out_rs1[0 +: RW], 0);
        chk("t1_imm0", bus.out_imm[0 +: DW], 5);
        chk("t1_useimm", bus.out_use_imm, 2'b01);
        chk("t1_rs1_1", bus.out_rs1[RW +: RW], 1);
        chk("t1_rs2_1", bus.out_rs2[RW +: RW], 2);
        chk("t1_rd1", bus.out_rd[RW +: RW], 3);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // fill to DEPTH, reject the extra batch, then drain in order
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, 2'b11, rand_inst(), rand_inst());
            cyc();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_count", bus.out_count, DEPTH);
        drive(1'b1, 2'b11, 32'h00100093, 32'h00100093);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_reject", bus.out_count, DEPTH);
        bus.out_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("pop_in_ready", bus.in_ready, 1);
        chk("pop_count", bus.out_count, DEPTH - 1);
        repeat (DEPTH) cyc();
        bus.out_ready = 1'b0;

        // partial lane mask, then an all-zero mask
        drive(1'b1, 2'b01, 32'h00500093, 32'h02208233);
        cyc();
        drive(1'b1, 2'b00, 32'h00500093, 32'h00500093);
        @(negedge clk);
        chk("mask_lv", bus.out_lane_valid, 2'b01);
        chk("mask_rd1", bus.out_rd[RW +: RW], 0);
        chk("mask_rs1_1", bus.out_rs1[RW +: RW], 0);
        chk("mask_fu1", bus.out_fu_type[2 +: 2], 0);
        chk("mask_rd0", bus.out_rd[0 +: RW], 1);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mask0_count", bus.out_count, 1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // nop plus an all-ones word
        drive(1'b1, 2'b11, 32'h00000013, 32'hFFFFFFFF);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("ill_flags", bus.out_illegal, 2'b10);
        chk("ill_imm1", bus.out_imm[DW +: DW], 0);
        chk("ill_fu1", bus.out_fu_type[2 +: 2], `ALU_TYPE_INT);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        // flush with three stored, concurrent with a push and a pop
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b11, rand_inst(), rand_inst());
            cyc();
        end
        drive(1'b1, 2'b11, 32'h00500093, 32'h002081B3);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("flush_count", bus.out_count, 0);
        chk("flush_valid", bus.out_valid, 0);

        // fadd.s
        drive(1'b1, 2'b01, 32'h00A57553, 32'h0);
        cyc();
        bus.in_valid = 1'b0;
        @(negedge clk);
`ifdef PREDECODE_FP_EN
        chk("fp_fu", bus.out_fu_type[0 +: 2], `ALU_TYPE_FO);
        chk("fp_flags", {bus.out_rs1_is_fp[0], bus.out_rs2_is_fp[0], bus.out_rd_is_fp[0]}, 3'b111);
        chk("fp_illegal", bus.out_illegal[0], 0);
`else
        chk("fp_illegal", bus.out_illegal[0], 1);
        chk("fp_flags", {bus.out_rs1_is_fp[0], bus.out_rs2_is_fp[0], bus.out_rd_is_fp[0]}, 3'b000);
`endif
        bus.out_ready = 1'b1;
        cyc();

        // randomized traffic with stall phases, occasional flush and one mid-stream reset
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0, LANES'($urandom()), rand_inst(), rand_inst());
            bus.out_ready = (c % 300 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 49) == 0);
            rst_n = (c != 700);
            cyc();
        end
        flush = 1'b0;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) cyc();
        @(negedge clk);
        chk("drain_count", bus.out_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
